// File: rtl/board_controller.sv
// Minesweeper board controller: game FSM, per-cell play state, cursor and 8-cycle neighbour scan.
// The per-cell read port is combinational so the VGA renderer can index it with its own cell coordinates.
module board_controller #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       new_game,
  input  logic [GRID_W*GRID_H-1:0]   mine_map,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [3:0]                 rd_x,
  input  logic [3:0]                 rd_y,
  output logic [1:0]                 rd_state,
  output logic [3:0]                 rd_count,
  output logic                       rd_mine,
  output logic                       rd_cursor,
  output logic [3:0]                 cursor_x,
  output logic [3:0]                 cursor_y,
  output logic [2:0]                 game_state,
  output logic [8:0]                 mine_count,
  output logic [8:0]                 revealed_count
);

  localparam int CELLS = GRID_W * GRID_H;

  localparam logic [1:0] CS_HIDDEN   = 2'd0;
  localparam logic [1:0] CS_REVEALED = 2'd1;
  localparam logic [1:0] CS_FLAGGED  = 2'd2;

  localparam logic [2:0] OP_UP     = 3'd1;
  localparam logic [2:0] OP_DOWN   = 3'd2;
  localparam logic [2:0] OP_LEFT   = 3'd3;
  localparam logic [2:0] OP_RIGHT  = 3'd4;
  localparam logic [2:0] OP_REVEAL = 3'd5;
  localparam logic [2:0] OP_FLAG   = 3'd6;

  // IDLE no game | LOAD count mines | PLAY take commands | SCAN count neighbours | LOST, WON terminal
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_SCAN = 3'd3,
    S_LOST = 3'd4,
    S_WON  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [CELLS-1:0]  mine_q;
  logic [1:0]        cell_state [CELLS];
  logic [3:0]        cell_count [CELLS];
  logic [7:0]        load_idx;
  logic [2:0]        scan_k;
  logic [3:0]        scan_acc;
  logic [3:0]        tgt_x, tgt_y;
  logic [3:0]        cur_x, cur_y;
  logic [8:0]        mines_q, revealed_q;

  logic [7:0]        cur_idx;
  logic [7:0]        rd_idx;
  logic              accept;
  logic [8:0]        mine_total;
  logic [8:0]        revealed_inc;
  logic [4:0]        dx, dy, nb_x, nb_y;
  logic              nb_mine;
  logic [3:0]        scan_sum;

  assign cur_idx      = {cur_y, cur_x};
  assign rd_idx       = {rd_y, rd_x};
  assign cmd_ready    = (state == S_PLAY) && !new_game;
  assign accept       = cmd_valid && cmd_ready;
  assign mine_total   = mines_q + {8'd0, mine_q[load_idx]};
  assign revealed_inc = revealed_q + 9'd1;

  // Offsets are 5-bit two's complement; bit 4 of the sum flags both -1 and 16 as off-board.
  always_comb begin
    dx = 5'd0;
    dy = 5'd0;
    case (scan_k)
      3'd0: begin dx = 5'h1F; dy = 5'h1F; end
      3'd1: dy = 5'h1F;
      3'd2: begin dx = 5'd1;  dy = 5'h1F; end
      3'd3: dx = 5'h1F;
      3'd4: dx = 5'd1;
      3'd5: begin dx = 5'h1F; dy = 5'd1;  end
      3'd6: dy = 5'd1;
      default: begin dx = 5'd1; dy = 5'd1; end
    endcase
  end

  assign nb_x     = {1'b0, tgt_x} + dx;
  assign nb_y     = {1'b0, tgt_y} + dy;
  assign nb_mine  = !nb_x[4] && !nb_y[4] && mine_q[{nb_y[3:0], nb_x[3:0]}];
  assign scan_sum = scan_acc + {3'd0, nb_mine};

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD:
          if (load_idx == 8'hFF) state_nxt = (mine_total == 9'd256) ? S_WON : S_PLAY;
        S_PLAY:
          if (accept && cmd_op == OP_REVEAL && cell_state[cur_idx] == CS_HIDDEN)
            state_nxt = mine_q[cur_idx] ? S_LOST : S_SCAN;
        S_SCAN:
          if (scan_k == 3'd7) state_nxt = (revealed_inc == 9'd256 - mines_q) ? S_WON : S_PLAY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mine_q <= '0;
      for (int i = 0; i < CELLS; i++) begin
        cell_state[i] <= CS_HIDDEN;
        cell_count[i] <= 4'd0;
      end
      load_idx   <= '0;
      scan_k     <= '0;
      scan_acc   <= '0;
      tgt_x      <= '0;
      tgt_y      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      mines_q    <= '0;
      revealed_q <= '0;
    end else if (new_game) begin
      mine_q <= mine_map;
      for (int i = 0; i < CELLS; i++) begin
        cell_state[i] <= CS_HIDDEN;
        cell_count[i] <= 4'd0;
      end
      load_idx   <= '0;
      scan_k     <= '0;
      scan_acc   <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      mines_q    <= '0;
      revealed_q <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          mines_q  <= mine_total;
          load_idx <= load_idx + 8'd1;
        end
        S_PLAY: if (accept) begin
          case (cmd_op)
            OP_UP:    if (cur_y != 4'd0)            cur_y <= cur_y - 4'd1;
            OP_DOWN:  if (cur_y != 4'(GRID_H - 1))  cur_y <= cur_y + 4'd1;
            OP_LEFT:  if (cur_x != 4'd0)            cur_x <= cur_x - 4'd1;
            OP_RIGHT: if (cur_x != 4'(GRID_W - 1))  cur_x <= cur_x + 4'd1;
            OP_FLAG: begin
              if (cell_state[cur_idx] == CS_HIDDEN)       cell_state[cur_idx] <= CS_FLAGGED;
              else if (cell_state[cur_idx] == CS_FLAGGED) cell_state[cur_idx] <= CS_HIDDEN;
            end
            OP_REVEAL: if (cell_state[cur_idx] == CS_HIDDEN) begin
              if (mine_q[cur_idx]) begin
                cell_state[cur_idx] <= CS_REVEALED;
              end else begin
                tgt_x    <= cur_x;
                tgt_y    <= cur_y;
                scan_k   <= 3'd0;
                scan_acc <= 4'd0;
              end
            end
            default: ;
          endcase
        end
        S_SCAN: begin
          scan_k   <= scan_k + 3'd1;
          scan_acc <= scan_sum;
          if (scan_k == 3'd7) begin
            cell_count[{tgt_y, tgt_x}] <= scan_sum;
            cell_state[{tgt_y, tgt_x}] <= CS_REVEALED;
            revealed_q                 <= revealed_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_state       = cell_state[rd_idx];
  assign rd_count       = cell_count[rd_idx];
  assign rd_mine        = mine_q[rd_idx];
  assign rd_cursor      = (rd_x == cur_x) && (rd_y == cur_y);
  assign cursor_x       = cur_x;
  assign cursor_y       = cur_y;
  assign game_state     = state;
  assign mine_count     = mines_q;
  assign revealed_count = revealed_q;

endmodule

// File: tb/tb_board_controller.sv
// Scoreboard bench for board_controller: the driver updates a board-level game model and queues
// expectations; a negedge monitor pops them when the DUT completes a command, game load or board sweep.
module tb_board_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         new_game;
  logic [255:0] mine_map;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [3:0]   rd_x, rd_y;
  logic [1:0]   rd_state;
  logic [3:0]   rd_count;
  logic         rd_mine, rd_cursor;
  logic [3:0]   cursor_x, cursor_y;
  logic [2:0]   game_state;
  logic [8:0]   mine_count, revealed_count;

  always #5 clk = ~clk;

  board_controller #(.GRID_W(16), .GRID_H(16)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .mine_map(mine_map),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .rd_x(rd_x), .rd_y(rd_y), .rd_state(rd_state), .rd_count(rd_count),
    .rd_mine(rd_mine), .rd_cursor(rd_cursor), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .game_state(game_state), .mine_count(mine_count), .revealed_count(revealed_count)
  );

  localparam int K_CMD = 0, K_GAME = 1, K_SWEEP = 2;

  typedef struct {
    int kind; int lat; int gs; int cx; int cy; int tx; int ty;
    int st; int cnt; int rev; int mines; int ready;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  bit m_mine [256];
  int m_state[256];
  int m_cnt  [256];
  int m_cx, m_cy, m_rev, m_mines, m_gs;
  logic [255:0] mm;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int neighbours(int x, int y);
    int n = 0;
    for (int ddy = -1; ddy <= 1; ddy++)
      for (int ddx = -1; ddx <= 1; ddx++)
        if ((ddx != 0 || ddy != 0) && x + ddx >= 0 && x + ddx < 16 && y + ddy >= 0 && y + ddy < 16)
          if (m_mine[(y + ddy) * 16 + x + ddx]) n++;
    return n;
  endfunction

  function automatic void reset_model(logic [255:0] map, int gs);
    for (int i = 0; i < 256; i++) begin
      m_mine[i]  = map[i];
      m_state[i] = 0;
      m_cnt[i]   = 0;
    end
    m_cx = 0; m_cy = 0; m_rev = 0;
    m_mines = $countones(map);
    m_gs = gs;
  endfunction

  function automatic exp_t snap(int kind, int lat);
    exp_t e;
    e.kind = kind; e.lat = lat; e.gs = m_gs;
    e.cx = m_cx; e.cy = m_cy; e.tx = m_cx; e.ty = m_cy;
    e.st = m_state[m_cy * 16 + m_cx]; e.cnt = m_cnt[m_cy * 16 + m_cx];
    e.rev = m_rev; e.mines = m_mines; e.ready = (m_gs == 2) ? 1 : 0;
    return e;
  endfunction

  task automatic sweep(exp_t e);
    int bad = -1;
    int a_st = 0, a_cnt = 0, a_mn = 0, a_cur = 0;
    check("sweep_game_state", int'(game_state), e.gs);
    check("sweep_cmd_ready", int'(cmd_ready), e.ready);
    check("sweep_cursor_x", int'(cursor_x), e.cx);
    check("sweep_cursor_y", int'(cursor_y), e.cy);
    check("sweep_revealed_count", int'(revealed_count), e.rev);
    check("sweep_mine_count", int'(mine_count), e.mines);
    for (int i = 0; i < 256; i++) begin
      rd_x = 4'(i % 16);
      rd_y = 4'(i / 16);
      #1;
      if (bad < 0 && (int'(rd_state) != m_state[i] || int'(rd_count) != m_cnt[i] ||
                      int'(rd_mine) != int'(m_mine[i]) ||
                      int'(rd_cursor) != ((i == e.cy * 16 + e.cx) ? 1 : 0))) begin
        bad = i; a_st = int'(rd_state); a_cnt = int'(rd_count);
        a_mn = int'(rd_mine); a_cur = int'(rd_cursor);
      end
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL sweep_board cell %0d: got state %0d count %0d mine %0d cursor %0d, expected state %0d count %0d mine %0d cursor %0d",
               bad, a_st, a_cnt, a_mn, a_cur, m_state[bad], m_cnt[bad], int'(m_mine[bad]),
               (bad == e.cy * 16 + e.cx) ? 1 : 0);
    end
  endtask

  initial begin : monitor
    int   low;
    exp_t e;
    low  = 0;
    rd_x = 4'd0;
    rd_y = 4'd0;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q[0];
        if (e.kind == K_SWEEP) begin
          sweep(e);
          void'(q.pop_front());
          low = 0;
        end else if (cmd_ready || game_state == 3'd5 || (e.kind == K_CMD && game_state == 3'd4)) begin
          check(e.kind == K_GAME ? "load_busy_cycles" : "cmd_busy_cycles", low, e.lat);
          check("game_state", int'(game_state), e.gs);
          check("cursor_x", int'(cursor_x), e.cx);
          check("cursor_y", int'(cursor_y), e.cy);
          check("revealed_count", int'(revealed_count), e.rev);
          check("mine_count", int'(mine_count), e.mines);
          rd_x = 4'(e.tx);
          rd_y = 4'(e.ty);
          #1;
          if (e.kind == K_CMD) begin
            check("cell_state", int'(rd_state), e.st);
            check("cell_count", int'(rd_count), e.cnt);
          end
          void'(q.pop_front());
          low = 0;
        end else begin
          low++;
          if (low > 400) begin
            check("response_timeout", low, e.lat);
            void'(q.pop_front());
            low = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("queue_drain", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic request_sweep();
    wait_idle();
    q.push_back(snap(K_SWEEP, 0));
    wait_idle();
  endtask

  task automatic start_game(logic [255:0] map);
    wait_idle();
    @(negedge clk);
    mine_map  = map;
    new_game  = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd6;
    @(posedge clk);
    #1;
    new_game  = 1'b0;
    cmd_valid = 1'b0;
    reset_model(map, ($countones(map) == 256) ? 5 : 2);
    q.push_back(snap(K_GAME, 256));
  endtask

  task automatic issue_cmd(int op);
    int idx;
    int lat = 0;
    wait_idle();
    @(negedge clk);
    cmd_op    = 3'(op);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    idx = m_cy * 16 + m_cx;
    case (op)
      1: if (m_cy > 0)  m_cy--;
      2: if (m_cy < 15) m_cy++;
      3: if (m_cx > 0)  m_cx--;
      4: if (m_cx < 15) m_cx++;
      5: if (m_state[idx] == 0) begin
           if (m_mine[idx]) begin
             m_state[idx] = 1;
             m_gs = 4;
           end else begin
             m_cnt[idx]   = neighbours(m_cx, m_cy);
             m_state[idx] = 1;
             m_rev++;
             lat = 8;
             if (m_rev == 256 - m_mines) m_gs = 5;
           end
         end
      6: if (m_state[idx] == 0) m_state[idx] = 2;
         else if (m_state[idx] == 2) m_state[idx] = 0;
      default: ;
    endcase
    q.push_back(snap(K_CMD, lat));
  endtask

  task automatic raw_reveal();
    wait_idle();
    @(negedge clk);
    cmd_op    = 3'd5;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  function automatic logic [255:0] rand_map(int one_in);
    logic [255:0] m;
    for (int i = 0; i < 256; i++) m[i] = ($urandom_range(0, one_in - 1) == 0);
    return m;
  endfunction

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst_n = 1'b0; new_game = 1'b0; mine_map = '0;
    cmd_valid = 1'b0; cmd_op = 3'd0;
    reset_model('0, 0);
    request_sweep();
    @(negedge clk);
    rst_n = 1'b1;

    mm = '0; mm[0] = 1'b1; mm[17] = 1'b1;
    start_game(mm);
    issue_cmd(3);
    issue_cmd(1);
    for (int i = 0; i < 20; i++) issue_cmd(4);

    mm = '0; mm[1] = 1'b1; mm[16] = 1'b1; mm[17] = 1'b1;
    start_game(mm);
    issue_cmd(5);
    for (int i = 0; i < 5; i++) begin issue_cmd(2); issue_cmd(4); end
    issue_cmd(6);
    issue_cmd(5);
    issue_cmd(6);
    request_sweep();
    for (int i = 0; i < 4; i++) begin issue_cmd(3); issue_cmd(1); end
    issue_cmd(5);
    wait_idle();
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_op = 3'($urandom_range(1, 6));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    request_sweep();

    mm = {1'b0, {255{1'b1}}};
    start_game(mm);
    for (int i = 0; i < 15; i++) begin issue_cmd(4); issue_cmd(2); end
    issue_cmd(5);
    request_sweep();

    start_game('1);
    request_sweep();

    mm = '0; mm[1] = 1'b1;
    start_game(mm);
    raw_reveal();
    repeat (3) @(negedge clk);
    check("abort_scan_in_progress", int'(game_state), 3);
    start_game(rand_map(6));
    request_sweep();

    start_game(mm);
    raw_reveal();
    repeat (3) @(negedge clk);
    check("reset_scan_in_progress", int'(game_state), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_game_state", int'(game_state), 0);
    check("async_reset_cmd_ready", int'(cmd_ready), 0);
    check("async_reset_cursor_x", int'(cursor_x), 0);
    check("async_reset_cursor_y", int'(cursor_y), 0);
    reset_model('0, 0);
    request_sweep();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      if (m_gs != 2) begin
        request_sweep();
        start_game(rand_map(($urandom_range(0, 3) == 0) ? 2 : 10));
      end else begin
        issue_cmd(int'($urandom_range(0, 7)));
      end
    end
    request_sweep();
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
